// File: rtl/instr_fetch_unit.sv
// Program-counter / fetch stage sitting in front of a small program ROM.
// Drives the ROM chip enable and address, captures the returned word into
// an instruction register and offers it to decode over a valid/ready
// handshake. Supports back-pressure, branch redirect with flush, and an
// end-of-program halt (WRAP=0) or wrap-around (WRAP=1).
module instr_fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RESET_PC   = 0,
  parameter bit          WRAP       = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic                  rom_ce,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  branch_en,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  halted
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PC_LAST  = '1;
  localparam logic [ADDR_WIDTH-1:0] PC_RESET = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE   = ADDR_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   instr_pc_q, instr_pc_d;
  logic                    valid_q, valid_d;
  logic                    halted_q, halted_d;

  logic                    load;
  logic                    transfer;
  logic                    pc_last;
  logic                    halt_now;

  // A load happens only while fetching, enabled, not redirecting, and with
  // room in the instruction register (empty, or being drained this cycle).
  assign load     = (state_q == ST_FETCH) && run && !branch_en &&
                    (!valid_q || instr_ready);
  assign transfer = valid_q && instr_ready;
  assign pc_last  = (pc_q == PC_LAST);
  // Without wrap, fetching the last address ends the program.
  assign halt_now = load && !WRAP && pc_last;

  // The reset cycle must never present an access to the ROM.
  assign rom_ce      = load && !reset;
  assign rom_address = pc_q;

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;

  // FSM next state: branch overrides the run transitions and leaves DONE.
  always_comb begin
    state_d = state_q;
    if (branch_en) begin
      if (state_q == ST_DONE) begin
        state_d = ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!run) begin
            state_d = ST_IDLE;
          end else if (halt_now) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath next state: branch flush, else load, else drain on transfer.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    if (branch_en) begin
      // Flush wins even over a simultaneous transfer.
      pc_d    = branch_target;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d    = rom_data;
      instr_pc_d = pc_q;
      valid_d    = 1'b1;
      if (!halt_now) begin
        pc_d = pc_q + PC_ONE;
      end
    end else if (transfer) begin
      valid_d = 1'b0;
    end
    halted_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous, highest-priority reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= PC_RESET;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (wrapping and halting) share
// the stimulus and a behavioural ROM. Every cycle both are checked against
// a reference model; a directed vector table and a halt sequence add
// hand-derived expectations, followed by a randomized run.
module tb_instr_fetch_unit;

  localparam int AW = 3;
  localparam int DW = 16;
  localparam int NW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, run, branch_en, instr_ready;
  logic [AW-1:0] branch_target;
  logic [DW-1:0] mem [NW];

  logic          ce_w, ce_h, v_w, v_h, h_w, h_h;
  logic [AW-1:0] addr_w, addr_h, ipc_w, ipc_h;
  logic [DW-1:0] data_w, data_h, instr_w, instr_h;

  assign data_w = mem[addr_w];
  assign data_h = mem[addr_h];

  instr_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(0), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .run(run), .rom_ce(ce_w), .rom_address(addr_w),
    .rom_data(data_w), .branch_en(branch_en), .branch_target(branch_target),
    .instr(instr_w), .instr_pc(ipc_w), .instr_valid(v_w),
    .instr_ready(instr_ready), .halted(h_w)
  );

  instr_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(0), .WRAP(1'b0)) dut_h (
    .clk(clk), .reset(reset), .run(run), .rom_ce(ce_h), .rom_address(addr_h),
    .rom_data(data_h), .branch_en(branch_en), .branch_target(branch_target),
    .instr(instr_h), .instr_pc(ipc_h), .instr_valid(v_h),
    .instr_ready(instr_ready), .halted(h_h)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model, index 0 = wrapping unit, 1 = halting unit.
  int        m_pc    [2];
  bit        m_act   [2];   // actively fetching
  bit        m_done  [2];   // program finished, waiting for a branch
  bit        m_valid [2];
  int        m_ipc   [2];
  logic [15:0] m_instr [2];

  // Values sampled just before the active edge.
  logic          s_ce_w, s_ce_h;
  logic [AW-1:0] s_addr_w, s_addr_h;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_load(input int k);
    return !reset && m_act[k] && run && !branch_en && (!m_valid[k] || instr_ready);
  endfunction

  task automatic m_step();
    for (int k = 0; k < 2; k++) begin
      bit ld;
      ld = m_load(k);
      if (reset) begin
        m_pc[k] = 0; m_act[k] = 0; m_done[k] = 0;
        m_valid[k] = 0; m_ipc[k] = 0; m_instr[k] = 16'h0;
      end else if (branch_en) begin
        m_pc[k] = int'(branch_target);
        m_valid[k] = 0;
        if (m_done[k]) begin
          m_done[k] = 0;
          m_act[k] = 1;
        end
      end else begin
        if (ld) begin
          m_instr[k] = mem[m_pc[k]];
          m_ipc[k] = m_pc[k];
          m_valid[k] = 1;
          if (k == 1 && m_pc[k] == NW - 1) begin
            m_done[k] = 1;
            m_act[k] = 0;
          end else begin
            m_pc[k] = (m_pc[k] + 1) % NW;
          end
        end else if (m_valid[k] && instr_ready) begin
          m_valid[k] = 0;
        end
        if (!m_done[k]) m_act[k] = run;
      end
    end
  endtask

  // One clock: check combinational outputs, clock, check registered outputs.
  task automatic cycle();
    #1;
    s_ce_w = ce_w; s_addr_w = addr_w; s_ce_h = ce_h; s_addr_h = addr_h;
    check("model rom_ce W", 32'(ce_w), 32'(m_load(0)));
    check("model rom_address W", 32'(addr_w), 32'(m_pc[0]));
    check("model rom_ce H", 32'(ce_h), 32'(m_load(1)));
    check("model rom_address H", 32'(addr_h), 32'(m_pc[1]));
    @(posedge clk);
    m_step();
    #1;
    check("model instr_valid W", 32'(v_w), 32'(m_valid[0]));
    check("model instr_pc W", 32'(ipc_w), 32'(m_ipc[0]));
    check("model instr W", 32'(instr_w), 32'(m_instr[0]));
    check("model halted W", 32'(h_w), 32'(m_done[0]));
    check("model instr_valid H", 32'(v_h), 32'(m_valid[1]));
    check("model instr_pc H", 32'(ipc_h), 32'(m_ipc[1]));
    check("model instr H", 32'(instr_h), 32'(m_instr[1]));
    check("model halted H", 32'(h_h), 32'(m_done[1]));
    @(negedge clk);
  endtask

  typedef struct {
    int rst, run, br, tgt, rdy;
    int e_ce, e_addr;
    int e_v, e_ipc, e_instr, e_h;
  } vec_t;

  vec_t vecs [$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst run br tgt rdy | ce addr | valid ipc instr halted   (WRAP=1 unit)
    vecs.push_back('{1,1,0,0,1, 0,0, 0,0,'h0000,0}); // reset
    vecs.push_back('{0,1,0,0,1, 0,0, 0,0,'h0000,0}); // IDLE -> FETCH
    vecs.push_back('{0,1,0,0,1, 1,0, 1,0,'h1000,0});
    vecs.push_back('{0,1,0,0,1, 1,1, 1,1,'h1001,0});
    vecs.push_back('{0,1,0,0,1, 1,2, 1,2,'h1002,0});
    vecs.push_back('{0,1,0,0,0, 0,3, 1,2,'h1002,0}); // stall x3
    vecs.push_back('{0,1,0,0,0, 0,3, 1,2,'h1002,0});
    vecs.push_back('{0,1,0,0,0, 0,3, 1,2,'h1002,0});
    vecs.push_back('{0,1,0,0,1, 1,3, 1,3,'h1003,0}); // release
    vecs.push_back('{0,0,0,0,1, 0,4, 0,3,'h1003,0}); // run drops at pc=4
    vecs.push_back('{0,0,0,0,1, 0,4, 0,3,'h1003,0});
    vecs.push_back('{0,1,0,0,1, 0,4, 0,3,'h1003,0}); // IDLE -> FETCH
    vecs.push_back('{0,1,0,0,1, 1,4, 1,4,'h1004,0});
    vecs.push_back('{0,1,0,0,1, 1,5, 1,5,'h1005,0});
    vecs.push_back('{0,1,0,0,1, 1,6, 1,6,'h1006,0});
    vecs.push_back('{0,1,0,0,1, 1,7, 1,7,'h1007,0});
    vecs.push_back('{0,1,0,0,1, 1,0, 1,0,'h1000,0}); // wrapped
    vecs.push_back('{0,1,0,0,1, 1,1, 1,1,'h1001,0});
    vecs.push_back('{0,1,1,6,0, 0,2, 0,1,'h1001,0}); // branch during stall
    vecs.push_back('{0,1,0,0,1, 1,6, 1,6,'h1006,0});
    vecs.push_back('{0,1,0,0,1, 1,7, 1,7,'h1007,0});
    vecs.push_back('{0,1,1,5,1, 0,0, 0,7,'h1007,0}); // branch + transfer
    vecs.push_back('{0,1,0,0,1, 1,5, 1,5,'h1005,0});
    vecs.push_back('{0,1,0,0,0, 0,6, 1,5,'h1005,0}); // stall at ipc=5
    vecs.push_back('{1,1,0,0,0, 0,6, 0,0,'h0000,0}); // reset mid-stall
    vecs.push_back('{0,0,0,0,1, 0,0, 0,0,'h0000,0});

    reset = 1'b1; run = 1'b0; branch_en = 1'b0; branch_target = '0; instr_ready = 1'b0;
    for (int a = 0; a < NW; a++) mem[a] = 16'h1000 + 16'(a);

    @(negedge clk);
    @(posedge clk);
    m_step();
    @(negedge clk);

    foreach (vecs[i]) begin
      reset         = vecs[i].rst[0];
      run           = vecs[i].run[0];
      branch_en     = vecs[i].br[0];
      branch_target = AW'(vecs[i].tgt);
      instr_ready   = vecs[i].rdy[0];
      cycle();
      check($sformatf("vec%0d rom_ce", i), 32'(s_ce_w), 32'(vecs[i].e_ce));
      check($sformatf("vec%0d rom_address", i), 32'(s_addr_w), 32'(vecs[i].e_addr));
      check($sformatf("vec%0d instr_valid", i), 32'(v_w), 32'(vecs[i].e_v));
      check($sformatf("vec%0d instr_pc", i), 32'(ipc_w), 32'(vecs[i].e_ipc));
      check($sformatf("vec%0d instr", i), 32'(instr_w), 32'(vecs[i].e_instr));
      check($sformatf("vec%0d halted", i), 32'(h_w), 32'(vecs[i].e_h));
      $display("vec %0d: rst=%0d run=%0d br=%0d rdy=%0d -> ce=%0d addr=%0d valid=%0d pc=%0d instr=%h halted=%0d",
               i, reset, run, branch_en, instr_ready, s_ce_w, s_addr_w, v_w, ipc_w, instr_w, h_w);
    end

    // Halting unit: free-run to the end of the program, then branch back.
    branch_en = 1'b0; reset = 1'b1; run = 1'b1; instr_ready = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 20 && !h_h; i++) cycle();
    check("halt reached", 32'(h_h), 32'(1));
    check("halt last instr_pc", 32'(ipc_h), 32'(7));
    check("halt last instr", 32'(instr_h), 32'h1007);
    check("halt last valid", 32'(v_h), 32'(1));
    $display("halt: halted=%0d pc=%0d instr=%h valid=%0d", h_h, ipc_h, instr_h, v_h);
    cycle();
    check("done rom_ce", 32'(s_ce_h), 32'(0));
    check("done drained valid", 32'(v_h), 32'(0));
    $display("done: ce=%0d valid=%0d", s_ce_h, v_h);
    cycle();
    check("done stays halted", 32'(h_h), 32'(1));
    check("done no reload", 32'(v_h), 32'(0));
    branch_en = 1'b1; branch_target = 3'd2;
    cycle();
    branch_en = 1'b0;
    check("branch clears halted", 32'(h_h), 32'(0));
    $display("branch out of done: halted=%0d", h_h);
    cycle();
    check("resume rom_ce", 32'(s_ce_h), 32'(1));
    check("resume rom_address", 32'(s_addr_h), 32'(2));
    check("resume instr_pc", 32'(ipc_h), 32'(2));
    check("resume instr", 32'(instr_h), 32'h1002);
    $display("resume: addr=%0d pc=%0d instr=%h", s_addr_h, ipc_h, instr_h);

    // Randomized traffic against the model.
    for (int a = 0; a < NW; a++) mem[a] = 16'($urandom);
    for (int n = 0; n < 1500; n++) begin
      reset         = ($urandom_range(0, 63) == 0);
      run           = ($urandom_range(0, 7) != 0);
      branch_en     = ($urandom_range(0, 9) == 0);
      branch_target = AW'($urandom_range(0, NW - 1));
      instr_ready   = ($urandom_range(0, 3) != 0);
      if (v_w && instr_ready && !reset && !branch_en)
        $display("xfer: pc=%0d instr=%h", ipc_w, instr_w);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
